i2c_pad_mux: RTL and testbench

Four-channel I2C pad fan-out between the single-channel I2C master and four physical sensor buses. Routes the master's SCL and SDA to one selected channel, returns the selected channel's SDA to the master through a synchronizer, and keeps a weak pull-up on every SDA pad. It sits at the top level directly on the package pins, in place of the hand-instantiated bidirectional buffer, output buffer and pull-up cells.

---
 rtl/i2c_pad_mux.sv | 106 ++++++++++
 tb/tb_i2c_pad_mux.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/i2c_pad_mux.sv
`default_nettype none
// ============================================================================
// Module      : i2c_pad_mux
// Description : Four-channel I2C pad fan-out with a bus-idle-deferred channel
//               select, weak SDA pull-ups and a synchronized SDA read-back.
// Revision    : 1.0 - initial release
// ============================================================================
module i2c_pad_mux #(
    parameter bit OPEN_DRAIN  = 1'b0,
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RES,
    input  logic [1:0] sel_req,
    input  logic       sel_load,
    input  logic       bus_busy,
    input  logic       scl_m,
    input  logic       sda_o,
    input  logic       sda_oe,
    output logic       sda_i,
    output logic [3:0] scl_pad,
    inout  wire  [3:0] sda_pad,
    output logic [1:0] active_sel,
    output logic       sel_pending
);

    localparam int c_CHANNELS = 4;

    logic [1:0] r_active_sel;
    logic [1:0] r_stored_sel;
    logic       r_sel_pending;
    logic       w_pad_level;

    // A load during a transaction is parked until the bus goes idle; a load
    // while idle (including the cycle busy falls) is applied immediately.
    always_ff @(posedge CLK) begin
        if (RES) begin
            r_active_sel  <= 2'd0;
            r_stored_sel  <= 2'd0;
            r_sel_pending <= 1'b0;
        end else if (sel_load) begin
            if (bus_busy) begin
                r_stored_sel  <= sel_req;
                r_sel_pending <= 1'b1;
            end else begin
                r_active_sel  <= sel_req;
                r_sel_pending <= 1'b0;
            end
        end else if (r_sel_pending && !bus_busy) begin
            r_active_sel  <= r_stored_sel;
            r_sel_pending <= 1'b0;
        end
    end

    assign active_sel  = r_active_sel;
    assign sel_pending = r_sel_pending;

    for (genvar g = 0; g < c_CHANNELS; g++) begin : g_chan
        logic w_is_active;
        logic w_drive_en;
        logic w_drive_val;

        assign w_is_active = (r_active_sel == 2'(g));
        assign scl_pad[g]  = w_is_active & scl_m;

        if (OPEN_DRAIN) begin : g_open_drain
            assign w_drive_en  = w_is_active & sda_oe & ~sda_o;
            assign w_drive_val = 1'b0;
        end else begin : g_push_pull
            assign w_drive_en  = w_is_active & sda_oe;
            assign w_drive_val = sda_o;
        end

        assign sda_pad[g] = w_drive_en ? w_drive_val : 1'bz;
        pullup u_sda_pullup (sda_pad[g]);
    end

    // Resolved pad level, so the master sees its own drive plus any device.
    assign w_pad_level = sda_pad[r_active_sel];

    if (SYNC_STAGES == 0) begin : g_sync_none
        assign sda_i = w_pad_level;
    end else if (SYNC_STAGES == 1) begin : g_sync_one
        logic r_sync;
        always_ff @(posedge CLK) begin
            if (RES) begin
                r_sync <= 1'b1;
            end else begin
                r_sync <= w_pad_level;
            end
        end
        assign sda_i = r_sync;
    end else begin : g_sync_multi
        logic [SYNC_STAGES-1:0] r_sync;
        always_ff @(posedge CLK) begin
            if (RES) begin
                r_sync <= '1;
            end else begin
                r_sync <= {r_sync[SYNC_STAGES-2:0], w_pad_level};
            end
        end
        assign sda_i = r_sync[SYNC_STAGES-1];
    end

endmodule
`default_nettype wire

// File: tb/tb_i2c_pad_mux.sv
`default_nettype none
// ============================================================================
// Module      : tb_i2c_pad_mux
// Description : Randomized bench for i2c_pad_mux, push-pull and open-drain
//               instances side by side against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_pad_mux;

    localparam int c_SYNC = 2;

    logic       CLK = 1'b0;
    logic       RES = 1'b1;
    logic [1:0] sel_req = 2'd0;
    logic       sel_load = 1'b0;
    logic       bus_busy = 1'b0;
    logic       scl_m = 1'b0;
    logic       sda_o = 1'b1;
    logic       sda_oe = 1'b0;
    logic [3:0] ext_low = 4'd0;

    wire  [3:0] pad_pp;
    wire  [3:0] pad_od;
    logic       sda_i_pp, sda_i_od;
    logic [3:0] scl_pp, scl_od;
    logic [1:0] act_pp, act_od;
    logic       pend_pp, pend_od;

    for (genvar g = 0; g < 4; g++) begin : g_ext
        assign pad_pp[g] = ext_low[g] ? 1'b0 : 1'bz;
        assign pad_od[g] = ext_low[g] ? 1'b0 : 1'bz;
    end

    i2c_pad_mux #(.OPEN_DRAIN(1'b0), .SYNC_STAGES(c_SYNC)) u_dut_pp (
        .CLK(CLK), .RES(RES), .sel_req(sel_req), .sel_load(sel_load),
        .bus_busy(bus_busy), .scl_m(scl_m), .sda_o(sda_o), .sda_oe(sda_oe),
        .sda_i(sda_i_pp), .scl_pad(scl_pp), .sda_pad(pad_pp),
        .active_sel(act_pp), .sel_pending(pend_pp)
    );

    i2c_pad_mux #(.OPEN_DRAIN(1'b1), .SYNC_STAGES(c_SYNC)) u_dut_od (
        .CLK(CLK), .RES(RES), .sel_req(sel_req), .sel_load(sel_load),
        .bus_busy(bus_busy), .scl_m(scl_m), .sda_o(sda_o), .sda_oe(sda_oe),
        .sda_i(sda_i_od), .scl_pad(scl_od), .sda_pad(pad_od),
        .active_sel(act_od), .sel_pending(pend_od)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model: routed channel, parked request (-1 = none), read-back pipelines.
    int m_act     = 0;
    int m_parked  = -1;
    bit q_pp[$];
    bit q_od[$];

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] exp_pads(input bit od);
        logic [3:0] r;
        for (int n = 0; n < 4; n++) begin
            bit drives_low  = (n == m_act) && sda_oe && !sda_o;
            bit drives_high = (n == m_act) && sda_oe && sda_o && !od;
            if (drives_low || ext_low[n])
                r[n] = 1'b0;
            else if (drives_high)
                r[n] = 1'b1;
            else
                r[n] = 1'b1;
        end
        return r;
    endfunction

    task automatic reset_pipes();
        q_pp.delete();
        q_od.delete();
        for (int i = 0; i < c_SYNC; i++) begin
            q_pp.push_back(1'b1);
            q_od.push_back(1'b1);
        end
    endtask

    task automatic step(input bit rst, input bit [1:0] req, input bit ld, input bit busy,
                        input bit scl, input bit o, input bit oe, input bit [3:0] ext);
        logic [3:0] e_pp, e_od, e_scl;
        bit lvl_pp, lvl_od;
        @(negedge CLK);
        RES = rst; sel_req = req; sel_load = ld; bus_busy = busy;
        scl_m = scl; sda_o = o; sda_oe = oe;
        // Never let the external device fight a push-pull high.
        ext_low = ext;
        if (oe && o) ext_low[m_act] = 1'b0;
        #1;
        e_scl = scl ? (4'b0001 << m_act) : 4'b0000;
        e_pp  = exp_pads(1'b0);
        e_od  = exp_pads(1'b1);
        check("scl_pp", {4'd0, scl_pp}, {4'd0, e_scl});
        check("scl_od", {4'd0, scl_od}, {4'd0, e_scl});
        check("pad_pp", {4'd0, pad_pp}, {4'd0, e_pp});
        check("pad_od", {4'd0, pad_od}, {4'd0, e_od});
        lvl_pp = e_pp[m_act];
        lvl_od = e_od[m_act];
        @(posedge CLK);
        if (rst) begin
            m_act = 0;
            m_parked = -1;
            reset_pipes();
        end else begin
            q_pp.push_back(lvl_pp); void'(q_pp.pop_front());
            q_od.push_back(lvl_od); void'(q_od.pop_front());
            if (ld && !busy) begin
                m_act = req;
                m_parked = -1;
            end else if (ld) begin
                m_parked = req;
            end else if (m_parked >= 0 && !busy) begin
                m_act = m_parked;
                m_parked = -1;
            end
        end
        #1;
        check("act_pp",  {6'd0, act_pp},  8'(m_act));
        check("act_od",  {6'd0, act_od},  8'(m_act));
        check("pend_pp", {7'd0, pend_pp}, {7'd0, m_parked >= 0});
        check("pend_od", {7'd0, pend_od}, {7'd0, m_parked >= 0});
        check("sdai_pp", {7'd0, sda_i_pp}, {7'd0, q_pp[0]});
        check("sdai_od", {7'd0, sda_i_od}, {7'd0, q_od[0]});
    endtask

    initial begin
        reset_pipes();
        //   rst req ld busy scl o  oe ext
        step(1, 0, 0, 0, 0, 1, 0, 4'h0);
        step(1, 3, 1, 0, 0, 1, 0, 4'h0);
        step(0, 0, 0, 0, 1, 1, 0, 4'h0);
        // Immediate select of channel 2, then drive a low on it.
        step(0, 2, 1, 0, 1, 1, 0, 4'h0);
        step(0, 0, 0, 0, 1, 0, 1, 4'h0);
        step(0, 0, 0, 0, 0, 1, 1, 4'h0);
        // Deferred loads while busy: last one wins once the bus idles.
        step(0, 3, 1, 1, 1, 1, 0, 4'h0);
        step(0, 1, 1, 1, 0, 1, 0, 4'h0);
        step(0, 0, 0, 1, 1, 1, 0, 4'h0);
        step(0, 0, 0, 0, 1, 1, 0, 4'h0);
        step(0, 0, 0, 0, 1, 1, 0, 4'h0);
        // Busy falling together with a fresh load: the fresh load wins.
        step(0, 2, 1, 1, 0, 1, 0, 4'h0);
        step(0, 3, 1, 0, 0, 1, 0, 4'h0);
        // Device pulls channel 3 low, then an inactive pad.
        step(0, 0, 0, 0, 0, 1, 0, 4'h8);
        step(0, 0, 0, 0, 0, 1, 0, 4'h8);
        step(0, 0, 0, 0, 0, 1, 0, 4'h8);
        step(0, 0, 0, 0, 0, 1, 0, 4'h1);
        step(0, 0, 0, 0, 0, 1, 0, 4'h1);
        step(0, 0, 0, 0, 0, 1, 0, 4'h1);
        // Master drive high vs low on both pad styles.
        step(0, 0, 0, 0, 1, 1, 1, 4'h0);
        step(0, 0, 0, 0, 1, 0, 1, 4'h0);
        step(0, 0, 0, 0, 1, 0, 1, 4'h0);
        step(0, 0, 0, 0, 1, 1, 1, 4'h0);
        // Reset in the middle of a transaction with a pending load.
        step(0, 2, 1, 0, 1, 0, 1, 4'h0);
        step(0, 1, 1, 1, 0, 0, 1, 4'h0);
        step(1, 3, 1, 1, 1, 0, 1, 4'h0);
        step(0, 0, 0, 1, 1, 0, 1, 4'h0);
        step(0, 0, 0, 0, 1, 0, 1, 4'h0);
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 31) == 0), 2'($urandom), ($urandom_range(0, 3) == 0),
                 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                 4'($urandom) & 4'($urandom));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
